// File: rtl/char_update_scheduler_if.sv
// ---------------------------------------------------------------------------
// char_update_scheduler_if
//   Groups the request, commit and status signals of char_update_scheduler.
//
//   master : the side that requests writes/clears and observes commits
//            (video timing + CPU side, or a testbench)
//   slave  : the scheduler itself
//
//   video_on     high while the visible area is being scanned
//   wr_req       one-cycle write request (wr_slot, wr_code)
//   wr_ready     FIFO can accept a write this cycle
//   clr_req      one-cycle pulse requesting a clear of all slots
//   commit_en    register-file write strobe (commit_slot, commit_code)
//   busy         clear pending or FIFO non-empty
//   overflow     sticky: a write was dropped
// ---------------------------------------------------------------------------
interface char_update_scheduler_if #(
    parameter int SLOT_W = 2,
    parameter int CODE_W = 7
);
    logic              video_on;
    logic              wr_req;
    logic [SLOT_W-1:0] wr_slot;
    logic [CODE_W-1:0] wr_code;
    logic              wr_ready;
    logic              clr_req;
    logic              commit_en;
    logic [SLOT_W-1:0] commit_slot;
    logic [CODE_W-1:0] commit_code;
    logic              busy;
    logic              overflow;

    modport master (
        output video_on, wr_req, wr_slot, wr_code, clr_req,
        input  wr_ready, commit_en, commit_slot, commit_code, busy, overflow
    );

    modport slave (
        input  video_on, wr_req, wr_slot, wr_code, clr_req,
        output wr_ready, commit_en, commit_slot, commit_code, busy, overflow
    );
endinterface

// File: rtl/char_update_scheduler.sv
// ---------------------------------------------------------------------------
// char_update_scheduler
//   Queues (slot, code) writes to the character-address register file and
//   commits them only during blanking, after a guard interval, so glyphs
//   never change mid-line. Also sequences a "clear all slots" operation,
//   which always completes before any queued write is drained.
//
//   clk    system clock, all state on rising edge
//   reset  asynchronous, active-high reset
//   bus    char_update_scheduler_if.slave (requests, commit strobe, status)
// ---------------------------------------------------------------------------
module char_update_scheduler #(
    parameter int              SLOTS      = 4,
    parameter int              SLOT_W     = 2,
    parameter int              CODE_W     = 7,
    parameter int              FIFO_DEPTH = 4,
    parameter int              GUARD      = 2,
    parameter logic [CODE_W-1:0] CLEAR_CODE = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    char_update_scheduler_if.slave   bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [CNT_W-1:0]  GUARD_LAST = CNT_W'(GUARD - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOTS - 1);
    localparam logic [PTR_W:0]    FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_ACTIVE,
        S_GUARD,
        S_DRAIN,
        S_CLEAR
    } state_t;

    state_t                      r_state;
    state_t                      w_next_state;
    logic [CNT_W-1:0]            r_guard_cnt;
    logic [CNT_W-1:0]            w_guard_cnt_next;
    logic [CNT_W-1:0]            w_guard_cnt_inc;
    logic                        r_clear_pending;
    logic [SLOT_W-1:0]           r_clear_idx;
    logic                        r_overflow;

    logic [SLOT_W+CODE_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]            r_wr_ptr;
    logic [PTR_W-1:0]            r_rd_ptr;
    logic [PTR_W:0]              r_count;

    logic                        w_full;
    logic                        w_empty;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_clear_step;
    logic                        w_clear_done;
    logic                        w_commit_en;
    logic [SLOT_W-1:0]           w_commit_slot;
    logic [CODE_W-1:0]           w_commit_code;

    assign w_full          = (r_count == FIFO_FULL);
    assign w_empty         = (r_count == '0);
    // A pop in this cycle never frees room for a push: full is registered.
    assign w_push          = bus.wr_req && !w_full;
    assign w_guard_cnt_inc = r_guard_cnt + CNT_W'(1);

    // ------------------------------------------------------------------
    // Next-state and Mealy commit outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        w_next_state     = r_state;
        w_guard_cnt_next = r_guard_cnt;
        w_commit_en      = 1'b0;
        w_commit_slot    = '0;
        w_commit_code    = '0;
        w_pop            = 1'b0;
        w_clear_step     = 1'b0;
        w_clear_done     = 1'b0;

        unique case (r_state)
            S_ACTIVE: begin
                if (!bus.video_on) begin
                    w_guard_cnt_next = '0;
                    // With a one-cycle guard the first blanking cycle is the
                    // whole guard, so commits may start on the next one.
                    w_next_state = (GUARD == 1) ? S_DRAIN : S_GUARD;
                end
            end

            S_GUARD: begin
                if (bus.video_on) begin
                    w_next_state = S_ACTIVE;
                end else begin
                    w_guard_cnt_next = w_guard_cnt_inc;
                    if (w_guard_cnt_inc == GUARD_LAST) begin
                        w_next_state = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                if (bus.video_on) begin
                    w_next_state = S_ACTIVE;
                end else if (r_clear_pending) begin
                    w_next_state = S_CLEAR;
                end else if (!w_empty) begin
                    w_commit_en = 1'b1;
                    {w_commit_slot, w_commit_code} = r_mem[r_rd_ptr];
                    w_pop = 1'b1;
                end
            end

            S_CLEAR: begin
                // Leaving on video_on keeps r_clear_idx so the clear resumes.
                if (bus.video_on) begin
                    w_next_state = S_ACTIVE;
                end else begin
                    w_commit_en   = 1'b1;
                    w_commit_slot = r_clear_idx;
                    w_commit_code = CLEAR_CODE;
                    w_clear_step  = 1'b1;
                    if (r_clear_idx == SLOT_LAST) begin
                        w_clear_done = 1'b1;
                        w_next_state = S_DRAIN;
                    end
                end
            end

            default: w_next_state = S_ACTIVE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_ACTIVE;
            r_guard_cnt     <= '0;
            r_clear_pending <= 1'b0;
            r_clear_idx     <= '0;
            r_overflow      <= 1'b0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
        end else begin
            r_state     <= w_next_state;
            r_guard_cnt <= w_guard_cnt_next;

            // Completion wins over a same-cycle clr_req: a request arriving
            // while a clear is still pending is a repeat and is ignored.
            if (w_clear_done) begin
                r_clear_pending <= 1'b0;
            end else if (bus.clr_req) begin
                r_clear_pending <= 1'b1;
            end

            if (w_clear_done) begin
                r_clear_idx <= '0;
            end else if (w_clear_step) begin
                r_clear_idx <= r_clear_idx + SLOT_W'(1);
            end

            if (bus.wr_req && w_full) begin
                r_overflow <= 1'b1;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; occupancy alone decides which entries
    // are valid, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.wr_slot, bus.wr_code};
        end
    end

    assign bus.wr_ready    = !w_full;
    assign bus.commit_en   = w_commit_en;
    assign bus.commit_slot = w_commit_slot;
    assign bus.commit_code = w_commit_code;
    assign bus.busy        = r_clear_pending | !w_empty;
    assign bus.overflow    = r_overflow;

endmodule

// File: doc/char_update_scheduler.md
Name: char_update_scheduler

Overview:
- Sequences updates to the character-address register file that feeds the font-ROM address generator.
- Accepts (slot, code) write requests at any time and queues them in a small FIFO.
- Commits queued writes to the register file only during blanking (video_on low), after a guard interval, so displayed glyphs never change mid-line.
- Also sequences a full "clear all slots" operation.

Parameters:
SLOTS, 4, number of character slots in the register file (power of 2)
SLOT_W, 2, slot index width, log2(SLOTS)
CODE_W, 7, character code width (upper font-ROM address bits)
FIFO_DEPTH, 4, queued write entries (power of 2, >=2)
GUARD, 2, blanking cycles to wait before first commit (>=1)
CLEAR_CODE, 0, code written to every slot by a clear

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
video_on  in  1  high while the visible area is being scanned
wr_req  in  1  write request, valid for one cycle
wr_slot  in  SLOT_W  target slot of the write
wr_code  in  CODE_W  character code to write
wr_ready  out  1  FIFO can accept a write this cycle
clr_req  in  1  single-cycle pulse requesting clear of all slots
commit_en  out  1  register-file write strobe
commit_slot  out  SLOT_W  register-file write index
commit_code  out  CODE_W  register-file write data
busy  out  1  clear pending or FIFO non-empty
overflow  out  1  sticky: a write was dropped

Behaviour:
- Reset (async): FIFO empty; state ACTIVE; guard counter 0; clear_pending 0; clear index 0; overflow 0. Outputs: wr_ready=1, commit_en=0, commit_slot=0, commit_code=0, busy=0.
- FIFO:
  - wr_ready = !full, from registered occupancy.
  - Push on wr_req && wr_ready.
  - wr_req while full: entry dropped and overflow set. overflow clears only on reset.
  - A pop in the same cycle as a full-state push does not rescue the push.
  - Push and pop in the same cycle on a non-full FIFO: occupancy unchanged.
  - Entries commit in arrival order. Pointers wrap modulo FIFO_DEPTH.
- clr_req sets clear_pending at the next edge. A repeat clr_req while pending is ignored.
- FSM:
  - ACTIVE: video_on=0 → GUARD, counter←0. Otherwise stay.
  - GUARD:
    - video_on=1 → ACTIVE.
    - Else counter++. When counter==GUARD-1 → DRAIN.
    - The first commit can occur on the (GUARD+1)-th consecutive blanking cycle.
  - DRAIN:
    - video_on=1 → ACTIVE.
    - Else if clear_pending → CLEAR.
    - Else stay.
  - CLEAR:
    - video_on=1 → ACTIVE; clear index retained.
    - Else one slot per cycle. After slot SLOTS-1: clear_pending←0, index←0, → DRAIN.
- Commit output (Mealy, same cycle):
  - commit_en=1 only when video_on=0 and either:
    - (a) state CLEAR: commit_slot=index, commit_code=CLEAR_CODE, index++; or
    - (b) state DRAIN, clear_pending=0, FIFO non-empty: commit_slot/code = FIFO head, popped at this edge.
  - Otherwise commit_en=0 and commit_slot/commit_code=0.
  - Throughput: one commit per clock.
- Ordering:
  - A clear always completes before any FIFO entry is drained.
  - Writes queued before or after the clear therefore land after the clear (they win).
- Interrupted clear: resumes at the held index in the next blanking interval, after a fresh guard.
- busy = clear_pending | !empty. It is combinational from registered state.
- Reset mid-clear or mid-drain: all pending work is discarded, with no further commits.

Test Plan:
- Reset, video_on=1, push (1,7'h41),(2,7'h42) → wr_ready=1, commit_en=0 throughout, busy=1.
- Drop video_on to 0 (GUARD=2) → commit_en low for 2 cycles, then (1,41h) and (2,42h) on consecutive cycles; busy=0 after.
- 5 writes while video_on=1 (depth 4) → wr_ready=0 after 4th; 5th dropped; overflow=1 and stays 1; the 4 accepted entries commit in order next blanking.
- clr_req plus queued (3,7'h55), then blanking → commits (0,0),(1,0),(2,0),(3,0), then (3,55h).
- Start a clear; raise video_on after slot 1 → commit_en=0 immediately. Next blanking, after 2 guard cycles → slots 2,3 cleared.
- Assert reset during DRAIN with 3 entries queued → commit_en=0 at once; wr_ready=1; busy=0; overflow=0.
